// File: rtl/toggle_stim_pkg.sv
// Shared types and default widths for the toggle stimulus generator.
package toggle_stim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 16;

endpackage

// File: rtl/toggle_stim_gen_chan.sv
// One square-wave channel: toggles its line every half cycles while enabled.
module toggle_chan #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] half,
  input  logic             clear,
  input  logic             en,
  output logic             out
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_out;
  logic             w_wrap;

  assign w_wrap = (r_cnt == half - CNT_W'(1));
  assign out    = r_out;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (clear) begin
      r_cnt <= '0;
      r_out <= 1'b0;
    end else if (en) begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_out <= ~r_out;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/toggle_stim_gen.sv
// Config-loaded dual square-wave source with run length, stop and done pulse.
module toggle_stim_gen
  import toggle_stim_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half0,
  input  logic [CNT_W-1:0] cfg_half1,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             stop,
  output logic             in0,
  output logic             in1,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_half0;
  logic [CNT_W-1:0] r_half1;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_run_cnt;
  logic             r_cfg_ready;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_len_hit;
  logic             w_end;
  logic             w_clear;
  logic             w_en;

  assign w_accept  = r_cfg_ready && cfg_valid;
  assign w_len_hit = (r_len != '0) &&
                     (r_run_cnt == r_len - LEN_W'(1));
  assign w_end     = (r_state == RUN) && (stop || w_len_hit);
  // Ending edge clears the lines, suppressing any toggle due then.
  assign w_clear   = w_accept || w_end;
  assign w_en      = (r_state == RUN) && !w_end;

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign done      = r_done;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_end)    w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt == RUN);
      r_done      <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_half0   <= '0;
      r_half1   <= '0;
      r_len     <= '0;
      r_run_cnt <= '0;
    end else if (w_accept) begin
      r_half0   <= (cfg_half0 == '0) ? CNT_W'(1) : cfg_half0;
      r_half1   <= (cfg_half1 == '0) ? CNT_W'(1) : cfg_half1;
      r_len     <= cfg_len;
      r_run_cnt <= '0;
    end else if (r_state == RUN && r_run_cnt != '1) begin
      r_run_cnt <= r_run_cnt + LEN_W'(1);
    end
  end

  toggle_chan #(.CNT_W(CNT_W)) u_chan0 (
    .clk   (clk),
    .rstn  (rstn),
    .half  (r_half0),
    .clear (w_clear),
    .en    (w_en),
    .out   (in0)
  );

  toggle_chan #(.CNT_W(CNT_W)) u_chan1 (
    .clk   (clk),
    .rstn  (rstn),
    .half  (r_half1),
    .clear (w_clear),
    .en    (w_en),
    .out   (in1)
  );

endmodule
